// File: rtl/carrier_gen_param_pkg.sv
// rtl/carrier_gen_param_pkg.sv - shared PWM carrier types and mask helper
package carrier_gen_param_pkg;

  typedef enum logic [1:0] {
    COUNT_UP     = 2'd0,
    COUNT_DOWN   = 2'd1,
    COUNT_UPDOWN = 2'd2
  } _count_mode;

  typedef enum logic [1:0] {
    NO_MASK     = 2'd0,
    MIN_MASK    = 2'd1,
    MAX_MASK    = 2'd2,
    MINMAX_MASK = 2'd3
  } _mask_mode;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } _carr_dir;

  // Masked update strobe: zero events pass for MIN/MINMAX, peak events for MAX/MINMAX
  function automatic logic mask_hit(_mask_mode m, logic z, logic p);
    return (z && (m == MIN_MASK || m == MINMAX_MASK)) ||
           (p && (m == MAX_MASK || m == MINMAX_MASK));
  endfunction

endpackage

// File: rtl/carrier_gen_param_prescaler.sv
// rtl/carrier_gen_param_prescaler.sv - clock prescaler producing the carrier count tick
module pwm_prescaler #(
  parameter int PSW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic [PSW-1:0] prescale,
  output logic           tick
);

  logic [PSW-1:0] r_cnt;

  // Tick whenever the count reaches the active prescale value; count wraps there
  assign tick = (r_cnt == prescale);

  // Free-running divider, cleared on idle/start/resync so phase restarts cleanly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/carrier_gen_param.sv
// rtl/carrier_gen_param.sv - shadowed, prescaled PWM carrier counter with zero/peak events
module carrier_gen_param
  import carrier_gen_param_pkg::*;
#(
  parameter int CW  = 16,
  parameter int PSW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [CW-1:0]  period,
  input  logic [CW-1:0]  init_carr,
  input  logic [PSW-1:0] prescale,
  input  _count_mode     count_mode,
  input  _mask_mode      mask_mode,
  input  _pwm_onoff      pwm_onoff,
  input  logic           sync_in,
  output logic [CW-1:0]  carrier,
  output logic           dir,
  output logic           zero_event,
  output logic           peak_event,
  output logic           mask_event,
  output logic           shadow_load
);

  logic [CW-1:0]  r_carrier;
  _carr_dir       r_dir;
  logic           r_zero;
  logic           r_peak;
  logic           r_mask;
  logic           r_shload;
  logic           r_run;
  logic [CW-1:0]  r_period_act;
  logic [PSW-1:0] r_prescale_act;
  _count_mode     r_mode_act;

  logic           w_tick;
  logic           w_clr;
  logic [CW-1:0]  w_init_start;
  logic [CW-1:0]  w_init_sync;
  logic [CW-1:0]  w_nxt_carrier;
  _carr_dir       w_nxt_dir;
  _carr_dir       w_bound_dir;
  logic           w_zero;
  logic           w_peak;
  logic           w_bound;
  logic           w_go_up;

  assign carrier     = r_carrier;
  assign dir         = r_dir;
  assign zero_event  = r_zero;
  assign peak_event  = r_peak;
  assign mask_event  = r_mask;
  assign shadow_load = r_shload;

  // Prescaler restarts whenever the counter is not free-running (idle, start, resync)
  assign w_clr = (pwm_onoff == PWM_OFF) || !r_run || sync_in;

  pwm_prescaler #(.PSW(PSW)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_clr),
    .prescale (r_prescale_act),
    .tick     (w_tick)
  );

  // Phase values are clamped so the carrier never starts above its peak
  assign w_init_start = (init_carr > period)       ? period       : init_carr;
  assign w_init_sync  = (init_carr > r_period_act) ? r_period_act : init_carr;

  // Direction after a boundary reload: DOWN mode always counts down; UPDOWN entered
  // from a DOWN boundary sits at peak, so it must continue downwards
  assign w_bound_dir = (count_mode == COUNT_DOWN ||
                        (count_mode == COUNT_UPDOWN && r_mode_act == COUNT_DOWN))
                       ? DIR_DOWN : DIR_UP;

  // Next carrier value, direction and events for one tick with a nonzero period
  always_comb begin
    w_nxt_carrier = r_carrier;
    w_nxt_dir     = r_dir;
    w_zero        = 1'b0;
    w_peak        = 1'b0;
    w_bound       = 1'b0;
    w_go_up       = 1'b0;
    case (r_mode_act)
      COUNT_DOWN: begin
        w_nxt_dir = DIR_DOWN;
        if (r_carrier == '0) begin
          w_nxt_carrier = r_period_act;
          w_peak        = 1'b1;
          w_bound       = 1'b1;
        end else begin
          w_nxt_carrier = r_carrier - CW'(1);
          w_zero        = (r_carrier == CW'(1));
        end
      end
      COUNT_UPDOWN: begin
        w_go_up = (r_dir == DIR_UP || r_carrier == '0) && (r_carrier < r_period_act);
        if (w_go_up) begin
          w_nxt_carrier = r_carrier + CW'(1);
          w_peak        = (w_nxt_carrier == r_period_act);
          w_nxt_dir     = w_peak ? DIR_DOWN : DIR_UP;
        end else begin
          w_nxt_carrier = r_carrier - CW'(1);
          w_zero        = (w_nxt_carrier == '0);
          w_bound       = w_zero;
          w_nxt_dir     = w_zero ? DIR_UP : DIR_DOWN;
        end
      end
      default: begin
        w_nxt_dir = DIR_UP;
        if (r_carrier >= r_period_act) begin
          w_nxt_carrier = '0;
          w_zero        = 1'b1;
          w_bound       = 1'b1;
        end else begin
          w_nxt_carrier = r_carrier + CW'(1);
          w_peak        = (w_nxt_carrier == r_period_act);
        end
      end
    endcase
  end

  // Carrier, shadow registers and registered event strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_carrier      <= '0;
      r_dir          <= DIR_UP;
      r_zero         <= 1'b0;
      r_peak         <= 1'b0;
      r_mask         <= 1'b0;
      r_shload       <= 1'b0;
      r_run          <= 1'b0;
      r_period_act   <= '0;
      r_prescale_act <= '0;
      r_mode_act     <= COUNT_UP;
    end else begin
      r_zero   <= 1'b0;
      r_peak   <= 1'b0;
      r_mask   <= 1'b0;
      r_shload <= 1'b0;
      if (pwm_onoff == PWM_OFF) begin
        r_run          <= 1'b0;
        r_carrier      <= '0;
        r_dir          <= DIR_UP;
        r_period_act   <= period;
        r_prescale_act <= prescale;
        r_mode_act     <= count_mode;
      end else if (!r_run) begin
        r_run          <= 1'b1;
        r_carrier      <= w_init_start;
        r_dir          <= (count_mode == COUNT_DOWN) ? DIR_DOWN : DIR_UP;
        r_period_act   <= period;
        r_prescale_act <= prescale;
        r_mode_act     <= count_mode;
        r_shload       <= 1'b1;
      end else if (sync_in) begin
        r_carrier <= w_init_sync;
        if (r_mode_act == COUNT_UPDOWN && w_init_sync == r_period_act) begin
          r_dir <= DIR_DOWN;
        end
      end else if (w_tick) begin
        if (r_period_act == '0) begin
          r_carrier      <= '0;
          r_dir          <= (count_mode == COUNT_DOWN) ? DIR_DOWN : DIR_UP;
          r_period_act   <= period;
          r_prescale_act <= prescale;
          r_mode_act     <= count_mode;
          r_shload       <= 1'b1;
        end else begin
          r_carrier <= w_nxt_carrier;
          r_dir     <= w_nxt_dir;
          r_zero    <= w_zero;
          r_peak    <= w_peak;
          r_mask    <= mask_hit(mask_mode, w_zero, w_peak);
          if (w_bound) begin
            r_period_act   <= period;
            r_prescale_act <= prescale;
            r_mode_act     <= count_mode;
            r_shload       <= 1'b1;
            r_dir          <= w_bound_dir;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_carrier_gen_param.sv
// tb/tb_carrier_gen_param.sv - scoreboard bench for carrier_gen_param
module tb_carrier_gen_param;
  import carrier_gen_param_pkg::*;

  localparam int CW  = 16;
  localparam int PSW = 8;

  logic           clk;
  logic           reset;
  logic [CW-1:0]  period;
  logic [CW-1:0]  init_carr;
  logic [PSW-1:0] prescale;
  _count_mode     count_mode;
  _mask_mode      mask_mode;
  _pwm_onoff      pwm_onoff;
  logic           sync_in;
  logic [CW-1:0]  carrier;
  logic           dir;
  logic           zero_event;
  logic           peak_event;
  logic           mask_event;
  logic           shadow_load;

  typedef struct {
    logic [CW-1:0] c;
    logic [4:0]    f;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;

  carrier_gen_param #(.CW(CW), .PSW(PSW)) dut (
    .clk         (clk),
    .reset       (reset),
    .period      (period),
    .init_carr   (init_carr),
    .prescale    (prescale),
    .count_mode  (count_mode),
    .mask_mode   (mask_mode),
    .pwm_onoff   (pwm_onoff),
    .sync_in     (sync_in),
    .carrier     (carrier),
    .dir         (dir),
    .zero_event  (zero_event),
    .peak_event  (peak_event),
    .mask_event  (mask_event),
    .shadow_load (shadow_load)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // flags = {dir, zero, peak, mask, shadow_load}
  task automatic push(input int c, input bit d, input bit z, input bit p, input bit m, input bit s);
    exp_t e;
    e.c = CW'(c);
    e.f = {d, z, p, m, s};
    exp_q.push_back(e);
  endtask

  task automatic run(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk($sformatf("%s_q_empty_%0d", tag, i), 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s_carrier_%0d", tag, i), 32'(carrier), 32'(e.c));
        chk($sformatf("%s_flags_%0d", tag, i),
            32'({dir, zero_event, peak_event, mask_event, shadow_load}), 32'(e.f));
      end
    end
  endtask

  task automatic go_off();
    pwm_onoff = PWM_OFF;
    sync_in   = 1'b0;
    push(0, 0, 0, 0, 0, 0);
    run("off", 1);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b0;
    period     = '0;
    init_carr  = '0;
    prescale   = '0;
    count_mode = COUNT_UP;
    mask_mode  = NO_MASK;
    pwm_onoff  = PWM_OFF;
    sync_in    = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_carrier", 32'(carrier), 32'd0);
    chk("rst_flags", 32'({dir, zero_event, peak_event, mask_event, shadow_load}), 32'd0);

    reset = 1'b1;
    go_off();

    // UP, period 4, every clk
    period = 16'd4; init_carr = 16'd0; prescale = 8'd0;
    count_mode = COUNT_UP; mask_mode = NO_MASK; pwm_onoff = PWM_ON;
    push(0, 0, 0, 0, 0, 1);
    push(1, 0, 0, 0, 0, 0); push(2, 0, 0, 0, 0, 0); push(3, 0, 0, 0, 0, 0);
    push(4, 0, 0, 1, 0, 0); push(0, 0, 1, 0, 0, 1);
    push(1, 0, 0, 0, 0, 0); push(2, 0, 0, 0, 0, 0);
    run("up4", 8);

    // UPDOWN, period 3, both extremes masked in
    go_off();
    period = 16'd3; count_mode = COUNT_UPDOWN; mask_mode = MINMAX_MASK; pwm_onoff = PWM_ON;
    push(0, 0, 0, 0, 0, 1);
    push(1, 0, 0, 0, 0, 0); push(2, 0, 0, 0, 0, 0); push(3, 1, 0, 1, 1, 0);
    push(2, 1, 0, 0, 0, 0); push(1, 1, 0, 0, 0, 0); push(0, 0, 1, 0, 1, 1);
    push(1, 0, 0, 0, 0, 0); push(2, 0, 0, 0, 0, 0); push(3, 1, 0, 1, 1, 0);
    run("updn3", 10);

    // Prescale 2 then 0 mid-period: new rate after the wrap only
    go_off();
    period = 16'd2; prescale = 8'd2; count_mode = COUNT_UP; mask_mode = MAX_MASK; pwm_onoff = PWM_ON;
    push(0, 0, 0, 0, 0, 1);
    push(0, 0, 0, 0, 0, 0); push(0, 0, 0, 0, 0, 0); push(1, 0, 0, 0, 0, 0);
    run("psc_a", 4);
    prescale = 8'd0;
    push(1, 0, 0, 0, 0, 0); push(1, 0, 0, 0, 0, 0); push(2, 0, 0, 1, 1, 0);
    push(2, 0, 0, 0, 0, 0); push(2, 0, 0, 0, 0, 0); push(0, 0, 1, 0, 0, 1);
    push(1, 0, 0, 0, 0, 0); push(2, 0, 0, 1, 1, 0); push(0, 0, 1, 0, 0, 1);
    run("psc_b", 9);

    // Period 10 -> 5 at carrier 7: takes effect after the wrap
    go_off();
    period = 16'd10; prescale = 8'd0; mask_mode = MIN_MASK; pwm_onoff = PWM_ON;
    push(0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 7; k++) push(k, 0, 0, 0, 0, 0);
    run("per_a", 8);
    period = 16'd5;
    push(8, 0, 0, 0, 0, 0); push(9, 0, 0, 0, 0, 0); push(10, 0, 0, 1, 0, 0);
    push(0, 0, 1, 0, 1, 1);
    for (int k = 1; k <= 4; k++) push(k, 0, 0, 0, 0, 0);
    push(5, 0, 0, 1, 0, 0); push(0, 0, 1, 0, 1, 1);
    run("per_b", 10);

    // Phase sync: no events, init clamped to period
    go_off();
    period = 16'd8; init_carr = 16'd3; mask_mode = MINMAX_MASK; pwm_onoff = PWM_ON;
    push(3, 0, 0, 0, 0, 1);
    push(4, 0, 0, 0, 0, 0); push(5, 0, 0, 0, 0, 0); push(6, 0, 0, 0, 0, 0);
    run("sync_a", 4);
    sync_in = 1'b1;
    push(3, 0, 0, 0, 0, 0);
    run("sync_b", 1);
    sync_in = 1'b0;
    push(4, 0, 0, 0, 0, 0); push(5, 0, 0, 0, 0, 0); push(6, 0, 0, 0, 0, 0);
    push(7, 0, 0, 0, 0, 0); push(8, 0, 0, 1, 1, 0); push(0, 0, 1, 0, 1, 1);
    run("sync_c", 6);
    sync_in = 1'b1; init_carr = 16'd12;
    push(8, 0, 0, 0, 0, 0);
    run("sync_clamp", 1);
    sync_in = 1'b0;
    push(0, 0, 1, 0, 1, 1); push(1, 0, 0, 0, 0, 0);
    push(2, 0, 0, 0, 0, 0); push(3, 0, 0, 0, 0, 0); push(4, 0, 0, 0, 0, 0); push(5, 0, 0, 0, 0, 0);
    run("sync_d", 6);

    // Async reset at carrier 5, restart in DOWN from init 2
    reset = 1'b0;
    #1;
    chk("arst_carrier", 32'(carrier), 32'd0);
    chk("arst_flags", 32'({dir, zero_event, peak_event, mask_event, shadow_load}), 32'd0);
    @(negedge clk);
    period = 16'd6; init_carr = 16'd2; count_mode = COUNT_DOWN; mask_mode = MIN_MASK;
    pwm_onoff = PWM_ON;
    reset = 1'b1;
    push(2, 1, 0, 0, 0, 1); push(1, 1, 0, 0, 0, 0); push(0, 1, 1, 0, 1, 0);
    push(6, 1, 0, 1, 0, 1); push(5, 1, 0, 0, 0, 0);
    run("down", 5);

    chk("q_left", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/carrier_gen_param.md
Name: carrier_gen_param

Overview:
Parametrised next-generation PWM carrier counter with configurable width, a clock prescaler, shadowed period/mode registers, a phase-sync input and explicit zero/peak event outputs. It drives the comparators of one PWM channel group. Counting follows the shared PKG_pwm count, mask and on/off modes. Period and mode changes take effect only at carrier boundaries, so no glitched cycle can occur.

Parameters:
CW, 16, carrier/period/phase width in bits (4..32)
PSW, 8, prescaler width in bits (1..16)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset (reset==0 clears all state)
period  in  CW  carrier peak value, shadowed
init_carr  in  CW  phase/start value, sampled on start and on sync_in
prescale  in  PSW  count tick every prescale+1 clk cycles, shadowed
count_mode  in  _count_mode  COUNT_UP / COUNT_DOWN / COUNT_UPDOWN, shadowed
mask_mode  in  _mask_mode  selects which events raise mask_event (live)
pwm_onoff  in  _pwm_onoff  PWM_ON runs; PWM_OFF holds idle
sync_in  in  1  single-cycle phase-resync pulse
carrier  out  CW  carrier value
dir  out  1  0 = counting up, 1 = counting down
zero_event  out  1  1-cycle pulse when carrier becomes 0
peak_event  out  1  1-cycle pulse when carrier becomes period_act
mask_event  out  1  1-cycle masked update strobe
shadow_load  out  1  1-cycle pulse when shadow registers reload

Behaviour:
- Reset (async, reset==0): carrier=0, dir=0, all event outputs 0, prescaler count=0, shadows=0 (period_act, prescale_act, mode_act).
- PWM_OFF: carrier=0, dir=0, prescaler cleared, events 0. Shadows copy inputs every cycle (transparent). shadow_load stays 0.
- Start (first PWM_ON cycle after OFF): carrier <= min(init_carr, period). dir <= 1 if count_mode==COUNT_DOWN, else 0. Shadows load and shadow_load=1.
- Tick: internal 1-cycle pulse when prescaler count == prescale_act. The prescaler then wraps to 0. prescale_act==0 gives a tick every cycle. Carrier changes only on a tick.
- COUNT_UP: carrier+1 per tick. At carrier>=period_act the next value is 0 (zero_event), giving a period of period_act+1 ticks. peak_event when carrier reaches period_act.
- COUNT_DOWN: carrier-1 per tick. At carrier==0 the next value is period_act (peak_event). zero_event when carrier reaches 0.
- COUNT_UPDOWN: counts up to period_act, then dir=1. Counts down to 0, then dir=0. Period is 2*period_act ticks. peak_event at period_act, zero_event at 0. Extremes are held for 1 tick only.
- Boundary = the tick on which carrier becomes 0 (UP, UPDOWN) or period_act (DOWN). On a boundary the shadows reload from the inputs, registered with that carrier update, and shadow_load=1. A new period therefore applies from the next period.
- period_act==0 while ON: carrier held 0, no events. Shadows reload every tick so a nonzero period is picked up.
- sync_in while ON has priority over the tick. carrier <= min(init_carr, period_act) and the prescaler is cleared. In UPDOWN mode, dir <= 1 if the loaded value equals period_act, else dir is unchanged. sync_in raises no zero/peak event even if the loaded value is 0 or peak.
- mask_event = (zero_event and mask_mode in {MIN_MASK, MINMAX_MASK}) or (peak_event and mask_mode in {MAX_MASK, MINMAX_MASK}). Any other mask_mode value gives 0. It is registered and coincident with the event.
- All events and shadow_load are registered and high in the same cycle that carrier shows the new value. Latency is 1 clk from the tick.
- Arithmetic is unsigned CW-bit. The down count never goes below 0 and the up count never exceeds period_act, so no wrap-around occurs.
- Reset mid-operation aborts immediately. After reset is released the block restarts via the start rule.

Decomposition:
- PKG_pwm: reuse _count_mode, _mask_mode, _pwm_onoff. Add typedef _carr_dir {DIR_UP, DIR_DOWN}.
- One sub-module, pwm_prescaler (PSW param; inputs clk, reset, clr, prescale; output tick).
- Counter, shadow and event logic live in carrier_gen_param.

Test Plan:
- CW=16, UP, period=4, prescale=0 -> carrier 0,1,2,3,4,0. peak_event at 4, zero_event and shadow_load at the wrap to 0. Period is 5 clk.
- UPDOWN, period=3, mask_mode=MINMAX_MASK -> carrier 0,1,2,3,2,1,0. dir=1 from 3. mask_event at 3 and at 0 only.
- prescale=2, UP, period=2 -> carrier steps every 3 clk. Change prescale to 0 mid-period -> new rate only after carrier returns to 0.
- UP, period=10 running, period changed to 5 at carrier=7 -> continues to 10, wraps to 0, then peaks at 5.
- UP, period=8, init_carr=3, sync_in at carrier=6 -> next carrier=3 with no event. init_carr=12 -> clamps to 8.
- reset=0 at carrier=5 -> all outputs 0 the same cycle. Release with PWM_ON, DOWN, init_carr=2 -> carrier 2,1,0,period.
